// File: rtl/wav_ahb_master.sv
// Single-transfer AHB-Lite master.
// Takes one request at a time, runs one NONSEQ SINGLE transfer and returns one
// response. Misaligned requests are answered with an error and never reach the
// bus. A wait-state limit turns a slave that never responds into a timeout error.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | ready for a request (o_req_ready high)
//  ADDR  | address phase, NONSEQ on the bus until i_hready is sampled
//  DATA  | data phase, write data driven, waiting for i_hready
//  RESP  | response presented, held until i_rsp_ready
module wav_ahb_master #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int TWIDTH = 16
) (
    input  logic              i_hclk,
    input  logic              i_hreset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [AWIDTH-1:0] i_req_addr,
    input  logic [DWIDTH-1:0] i_req_wdata,
    input  logic [2:0]        i_req_size,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DWIDTH-1:0] o_rsp_rdata,
    output logic              o_rsp_error,
    output logic              o_rsp_timeout,
    input  logic [TWIDTH-1:0] i_tmo_cycles,
    output logic [AWIDTH-1:0] o_haddr,
    output logic              o_hwrite,
    output logic [DWIDTH-1:0] o_hwdata,
    output logic [1:0]        o_htrans,
    output logic [2:0]        o_hsize,
    output logic [2:0]        o_hburst,
    input  logic              i_hready,
    input  logic [DWIDTH-1:0] i_hrdata,
    input  logic [1:0]        i_hresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    state_t            state_q, state_d;
    logic [TWIDTH-1:0] cnt_q, cnt_d;
    logic [AWIDTH-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [DWIDTH-1:0] hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic              accept;
    logic              misaligned;
    logic [TWIDTH-1:0] cnt_inc;
    logic              tmo_hit;

    // Request handshake is combinational so a request can be taken the cycle IDLE is reached.
    assign o_req_ready = (state_q == ST_IDLE) && !i_hreset;
    assign accept      = i_req_valid && (state_q == ST_IDLE);

    // Alignment check on the incoming request; sizes above a word are rejected too.
    always_comb begin
        misaligned = 1'b0;
        if (i_req_size > 3'd2)
            misaligned = 1'b1;
        else if (i_req_size == 3'd2 && i_req_addr[1:0] != 2'b00)
            misaligned = 1'b1;
        else if (i_req_size == 3'd1 && i_req_addr[0])
            misaligned = 1'b1;
    end

    // Stall counter increments saturate so a disabled limit can never wrap into a false hit.
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        tmo_hit = (i_tmo_cycles != '0) && (cnt_inc >= i_tmo_cycles);
    end

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        haddr_d       = haddr_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        wdata_d       = wdata_q;
        htrans_d      = htrans_q;
        hwdata_d      = hwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    haddr_d  = i_req_addr;
                    hwrite_d = i_req_write;
                    hsize_d  = i_req_size;
                    wdata_d  = i_req_wdata;
                    if (misaligned) begin
                        state_d       = ST_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_error_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d  = ST_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        cnt_d    = '0;
                    end
                end
            end
            ST_ADDR: begin
                // hready wins over a timeout landing on the same edge.
                if (i_hready) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    cnt_d    = '0;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                end else if (tmo_hit) begin
                    state_d       = ST_RESP;
                    htrans_d      = HTRANS_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DATA: begin
                // hresp is only meaningful with hready high; the first ERROR cycle is ignored.
                if (i_hready) begin
                    state_d       = ST_RESP;
                    hwdata_d      = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = hwrite_q ? '0 : i_hrdata;
                    rsp_error_d   = (i_hresp == HRESP_ERROR);
                    rsp_timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d       = ST_RESP;
                    hwdata_d      = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d       = ST_IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_error_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer without a response.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hsize_q       <= '0;
            wdata_q       <= '0;
            htrans_q      <= HTRANS_IDLE;
            hwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            wdata_q       <= wdata_d;
            htrans_q      <= htrans_d;
            hwdata_q      <= hwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign o_haddr       = haddr_q;
    assign o_hwrite      = hwrite_q;
    assign o_hsize       = hsize_q;
    assign o_htrans      = htrans_q;
    assign o_hwdata      = hwdata_q;
    assign o_hburst      = 3'b000;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_error   = rsp_error_q;
    assign o_rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/wav_ahb_master.md
WAV_AHB_MASTER -- requirements
Module: wav_ahb_master

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, meaning AHB address width.
REQ-002 SHALL have parameter DWIDTH, default 32, meaning AHB data width.
REQ-003 SHALL have parameter TWIDTH, default 16, meaning timeout counter width.
REQ-004 SHALL have ports (one clock; reset is synchronous and active-high):
- i_hclk  input  1  clock
- i_hreset  input  1  synchronous active-high reset
- i_req_valid  input  1  request valid
- o_req_ready  output  1  request accepted when high with i_req_valid
- i_req_write  input  1  1=write, 0=read
- i_req_addr  input  AWIDTH  byte address
- i_req_wdata  input  DWIDTH  write data
- i_req_size  input  3  HSIZE encoding (0=byte, 1=half, 2=word)
- o_rsp_valid  output  1  response valid, held until i_rsp_ready
- i_rsp_ready  input  1  response consumed
- o_rsp_rdata  output  DWIDTH  read data (0 for writes)
- o_rsp_error  output  1  bus ERROR, misalignment or timeout
- o_rsp_timeout  output  1  error caused by timeout
- i_tmo_cycles  input  TWIDTH  wait-state limit; 0 disables timeout
- o_haddr  output  AWIDTH  AHB address
- o_hwrite  output  1  AHB write
- o_hwdata  output  DWIDTH  AHB write data
- o_htrans  output  2  AHB transfer type
- o_hsize  output  3  AHB size
- o_hburst  output  3  AHB burst, constant 3'b000 (SINGLE)
- i_hready  input  1  AHB ready
- i_hrdata  input  DWIDTH  AHB read data
- i_hresp  input  2  AHB response (2'b00 OKAY, 2'b01 ERROR)

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, DATA, RESP; all outputs registered except o_req_ready.
REQ-006 SHALL assert o_req_ready only in IDLE; request accepted on i_req_valid & o_req_ready.
REQ-007 SHALL, on accept, latch write/addr/wdata/size; if aligned go ADDR next cycle.
REQ-008 SHALL treat size 2 with addr[1:0]!=0, or size 1 with addr[0]!=0, or size>2, as misaligned: go RESP directly with o_rsp_error=1, o_rsp_timeout=0, no bus transfer (o_htrans stays IDLE).
REQ-009 SHALL in ADDR drive o_htrans=2'b10 (NONSEQ), o_haddr, o_hwrite, o_hsize from latched request; hold them stable while i_hready=0.
REQ-010 SHALL leave ADDR when i_hready=1 is sampled; enter DATA with o_htrans=2'b00 (IDLE).
REQ-011 SHALL drive o_hwdata with latched write data throughout DATA for writes; o_hwdata SHALL be 0 otherwise.
REQ-012 SHALL in DATA, on sampled i_hready=1, capture o_rsp_rdata=i_hrdata (reads) or 0 (writes), o_rsp_error=(i_hresp==2'b01), go RESP.
REQ-013 SHALL ignore i_hresp while i_hready=0 (first cycle of two-cycle ERROR response).
REQ-014 SHALL count consecutive i_hready=0 cycles in ADDR and DATA; counter clears on entering ADDR and on ADDR->DATA transition.
REQ-015 SHALL, when i_tmo_cycles!=0 and count reaches i_tmo_cycles with i_hready still 0, go RESP with o_rsp_error=1, o_rsp_timeout=1, o_rsp_rdata=0, and o_htrans=IDLE.
REQ-016 SHALL give i_hready=1 priority over timeout in the same cycle.
REQ-017 SHALL assert o_rsp_valid in RESP; on i_rsp_ready=1 deassert it and return to IDLE next cycle.
REQ-018 SHALL have a minimum latency of 3 cycles from accept to o_rsp_valid with zero wait states (ADDR, DATA, RESP); one new request per 4 cycles maximum.
REQ-019 SHALL hold o_rsp_rdata/o_rsp_error/o_rsp_timeout stable in RESP and clear them on leaving RESP.

Reset
REQ-020 SHALL on i_hreset=1 at a clock edge enter IDLE, clear counter and set all outputs to 0 (o_htrans=IDLE, o_hburst=0, o_rsp_valid=0), including mid-transfer; no response is produced for an aborted request.
REQ-021 SHALL assert o_req_ready in the first cycle after reset deasserts.

Verification
REQ-022 Read addr 0x10, size 2, zero waits, i_hrdata=0xDEADBEEF -> NONSEQ one cycle, o_rsp_valid 3 cycles after accept, rdata 0xDEADBEEF, error 0.
REQ-023 Write addr 0x24 data 0x12345678, 2 wait states in data phase -> o_hwdata=0x12345678 held 3 cycles, response error 0, rdata 0.
REQ-024 Slave two-cycle ERROR (hready=0/hresp=01 then hready=1/hresp=01) on read -> o_rsp_error=1, o_rsp_timeout=0.
REQ-025 i_tmo_cycles=4, i_hready held 0 -> RESP after 4 stall cycles, error=1, timeout=1; with i_tmo_cycles=0 -> waits indefinitely.
REQ-026 Word request addr 0x02 -> error response without NONSEQ on o_htrans; reset asserted during DATA -> all outputs 0 next cycle, o_req_ready=1 after release.
REQ-027 i_rsp_ready held 0 for 5 cycles -> o_rsp_valid and data stable, o_req_ready=0 throughout.
